// File: rtl/core_pkg.sv
// core: shared core-wide widths, writeback request type and a popcount helper.
package core;
   localparam int XLEN          = 32;
   localparam int REG_IDX_W     = 5;
   localparam int NUM_ARCH_REGS = 32;
   localparam int CNT_W         = 6;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      logic            en;
      reg_idx_t        rd_num;
      logic [XLEN-1:0] rd_value;
   } rf_write_req_t;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ARCH_REGS-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_ARCH_REGS; i++) c = c + {{(CNT_W-1){1'b0}}, v[i]};
      return c;
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with reserve/writeback/flush handling,
// reserve conflict detection and a registered busy popcount.
module rf_scoreboard (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  core::reg_idx_t        wr_num,
   input  logic                  rsv_en,
   input  core::reg_idx_t        rsv_num,
   input  logic                  flush,
   input  core::reg_idx_t        rs1_num,
   input  core::reg_idx_t        rs2_num,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  rsv_conflict,
   output logic [core::CNT_W-1:0] busy_count
);
   import core::*;

   logic [NUM_ARCH_REGS-1:0] r_busy;
   logic [NUM_ARCH_REGS-1:0] w_busy_nxt;
   logic [CNT_W-1:0]         r_count;
   logic                     w_rsv_valid;
   logic                     w_wb_same;
   logic                     w_rsv_set;

   assign w_rsv_valid  = rsv_en && rsv_num != '0;
   assign w_wb_same    = wr_en && wr_num == rsv_num;
   // a writeback retiring the same register frees it for this reserve
   assign rsv_conflict = w_rsv_valid && r_busy[rsv_num] && !w_wb_same;
   assign w_rsv_set    = w_rsv_valid && !rsv_conflict && !flush;

   always_comb begin
      w_busy_nxt = r_busy;
      if (wr_en) w_busy_nxt[wr_num] = 1'b0;
      if (w_rsv_set) w_busy_nxt[rsv_num] = 1'b1;
      if (flush) w_busy_nxt = '0;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy  <= '0;
         r_count <= '0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_count <= popcount(w_busy_nxt);
      end
   end

   assign rs1_busy   = r_busy[rs1_num] && !(wr_en && wr_num == rs1_num);
   assign rs2_busy   = r_busy[rs2_num] && !(wr_en && wr_num == rs2_num);
   assign busy_count = r_count;
endmodule

// File: rtl/reg_file.sv
// reg_file: integer register file with two combinational read ports, optional
// same-cycle write forwarding, and an issue scoreboard.
module reg_file #(
   parameter int XLEN     = core::XLEN,
   parameter int NUM_REGS = core::NUM_ARCH_REGS,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  core::rf_write_req_t     rf_write_req,
   input  core::reg_idx_t          rs1_num,
   input  core::reg_idx_t          rs2_num,
   output logic [XLEN-1:0]         rs1_value,
   output logic [XLEN-1:0]         rs2_value,
   output logic                    rs1_busy,
   output logic                    rs2_busy,
   input  logic                    rsv_en,
   input  core::reg_idx_t          rsv_num,
   output logic                    rsv_conflict,
   input  logic                    flush,
   output logic [core::CNT_W-1:0]  busy_count
);
   import core::*;

   logic [XLEN-1:0] r_regs [NUM_REGS];
   logic            w_wr;
   logic            w_fwd1;
   logic            w_fwd2;
   logic            w_sb_rs1_busy;
   logic            w_sb_rs2_busy;
   logic            w_sb_conflict;

   assign w_wr = rf_write_req.en && rf_write_req.rd_num != '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_wr) begin
         r_regs[rf_write_req.rd_num] <= rf_write_req.rd_value;
      end
   end

   assign w_fwd1 = BYPASS && w_wr && rf_write_req.rd_num == rs1_num;
   assign w_fwd2 = BYPASS && w_wr && rf_write_req.rd_num == rs2_num;

   // outputs are forced quiet while reset is held, including the forward path
   assign rs1_value = (!rst || rs1_num == '0) ? '0 : w_fwd1 ? rf_write_req.rd_value : r_regs[rs1_num];
   assign rs2_value = (!rst || rs2_num == '0) ? '0 : w_fwd2 ? rf_write_req.rd_value : r_regs[rs2_num];

   rf_scoreboard u_sb (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (rf_write_req.en),
      .wr_num       (rf_write_req.rd_num),
      .rsv_en       (rsv_en),
      .rsv_num      (rsv_num),
      .flush        (flush),
      .rs1_num      (rs1_num),
      .rs2_num      (rs2_num),
      .rs1_busy     (w_sb_rs1_busy),
      .rs2_busy     (w_sb_rs2_busy),
      .rsv_conflict (w_sb_conflict),
      .busy_count   (busy_count)
   );

   assign rs1_busy     = rst && w_sb_rs1_busy;
   assign rs2_busy     = rst && w_sb_rs2_busy;
   assign rsv_conflict = rst && w_sb_conflict;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed table-driven checks of reg_file plus hand sequences
// for BYPASS=0 behaviour and asynchronous reset.
module tb_reg_file;
   logic                clk = 1'b0;
   logic                rst;
   core::rf_write_req_t wr;
   logic [4:0]          rs1_num, rs2_num, rsv_num;
   logic                rsv_en, flush;
   logic [31:0]         rs1_value, rs2_value, nb_rs1_value, nb_rs2_value;
   logic                rs1_busy, rs2_busy, rsv_conflict;
   logic                nb_rs1_busy, nb_rs2_busy, nb_rsv_conflict;
   logic [5:0]          busy_count, nb_busy_count;
   int                  n_cmp = 0;
   int                  n_bad = 0;

   always #5 clk = ~clk;

   reg_file u_dut (
      .clk(clk), .rst(rst), .rf_write_req(wr), .rs1_num(rs1_num), .rs2_num(rs2_num),
      .rs1_value(rs1_value), .rs2_value(rs2_value), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rsv_en(rsv_en), .rsv_num(rsv_num), .rsv_conflict(rsv_conflict), .flush(flush),
      .busy_count(busy_count)
   );

   reg_file #(.BYPASS(1'b0)) u_nb (
      .clk(clk), .rst(rst), .rf_write_req(wr), .rs1_num(rs1_num), .rs2_num(rs2_num),
      .rs1_value(nb_rs1_value), .rs2_value(nb_rs2_value), .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
      .rsv_en(rsv_en), .rsv_num(rsv_num), .rsv_conflict(nb_rsv_conflict), .flush(flush),
      .busy_count(nb_busy_count)
   );

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        re;
      logic [4:0]  rn;
      logic        fl;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        eb1;
      logic        eb2;
      logic        ec;
      logic [5:0]  ecnt;
   } vec_t;

   vec_t tv [22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic re, input logic [4:0] rn, input logic fl);
      wr.en = we; wr.rd_num = rd; wr.rd_value = wd;
      rs1_num = r1; rs2_num = r2; rsv_en = re; rsv_num = rn; flush = fl;
   endtask

   initial begin
      //            we rd  wd            r1  r2  re rn  fl  e1            e2            b1 b2 c  cnt
      tv[0]  = '{1, 5,  32'hDEADBEEF, 5,  0,  0, 0,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0, 0};
      tv[1]  = '{0, 0,  32'h0,        5,  0,  0, 0,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0, 0};
      tv[2]  = '{1, 0,  32'h1234,     0,  0,  0, 0,  0,  32'h0,        32'h0,        0, 0, 0, 0};
      tv[3]  = '{0, 0,  32'h0,        0,  5,  0, 0,  0,  32'h0,        32'hDEADBEEF, 0, 0, 0, 0};
      tv[4]  = '{0, 0,  32'h0,        7,  0,  1, 7,  0,  32'h0,        32'h0,        0, 0, 0, 1};
      tv[5]  = '{1, 7,  32'hA5A5A5A5, 7,  7,  0, 0,  0,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 0};
      tv[6]  = '{0, 0,  32'h0,        3,  0,  1, 3,  0,  32'h0,        32'h0,        0, 0, 0, 1};
      tv[7]  = '{0, 0,  32'h0,        3,  0,  1, 3,  0,  32'h0,        32'h0,        1, 0, 1, 1};
      tv[8]  = '{1, 3,  32'h33,       3,  0,  0, 0,  0,  32'h33,       32'h0,        0, 0, 0, 0};
      tv[9]  = '{0, 0,  32'h0,        0,  0,  1, 9,  0,  32'h0,        32'h0,        0, 0, 0, 1};
      tv[10] = '{1, 9,  32'h99,       9,  0,  1, 9,  0,  32'h99,       32'h0,        0, 0, 0, 1};
      tv[11] = '{0, 0,  32'h0,        9,  7,  0, 0,  0,  32'h99,       32'hA5A5A5A5, 1, 0, 0, 1};
      tv[12] = '{1, 9,  32'h999,      9,  0,  0, 0,  0,  32'h999,      32'h0,        0, 0, 0, 0};
      tv[13] = '{0, 0,  32'h0,        0,  0,  1, 1,  0,  32'h0,        32'h0,        0, 0, 0, 1};
      tv[14] = '{0, 0,  32'h0,        0,  0,  1, 2,  0,  32'h0,        32'h0,        0, 0, 0, 2};
      tv[15] = '{0, 0,  32'h0,        1,  2,  1, 4,  0,  32'h0,        32'h0,        1, 1, 0, 3};
      tv[16] = '{1, 12, 32'hC,        4,  6,  1, 6,  1,  32'h0,        32'h0,        1, 0, 0, 0};
      tv[17] = '{0, 0,  32'h0,        12, 6,  0, 0,  0,  32'hC,        32'h0,        0, 0, 0, 0};
      tv[18] = '{0, 0,  32'h0,        0,  0,  1, 0,  0,  32'h0,        32'h0,        0, 0, 0, 0};
      tv[19] = '{0, 0,  32'h0,        31, 0,  1, 31, 0,  32'h0,        32'h0,        0, 0, 0, 1};
      tv[20] = '{0, 0,  32'h0,        31, 0,  1, 31, 0,  32'h0,        32'h0,        1, 0, 1, 1};
      tv[21] = '{1, 31, 32'h31,       31, 0,  0, 0,  0,  32'h31,       32'h0,        0, 0, 0, 0};

      rst = 1'b0;
      drive(0, 0, 0, 5, 9, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rs1_value", rs1_value, 32'h0);
      chk("reset_busy_count", {26'h0, busy_count}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 22; i++) begin
         drive(tv[i].we, tv[i].rd, tv[i].wd, tv[i].r1, tv[i].r2, tv[i].re, tv[i].rn, tv[i].fl);
         @(negedge clk);
         chk($sformatf("v%0d_rs1_value", i), rs1_value, tv[i].e1);
         chk($sformatf("v%0d_rs2_value", i), rs2_value, tv[i].e2);
         chk($sformatf("v%0d_rs1_busy", i), {31'h0, rs1_busy}, {31'h0, tv[i].eb1});
         chk($sformatf("v%0d_rs2_busy", i), {31'h0, rs2_busy}, {31'h0, tv[i].eb2});
         chk($sformatf("v%0d_rsv_conflict", i), {31'h0, rsv_conflict}, {31'h0, tv[i].ec});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_busy_count", i), {26'h0, busy_count}, {26'h0, tv[i].ecnt});
      end

      // BYPASS=0 instance must show the stored value until the edge
      drive(1, 7, 32'h1, 7, 0, 0, 0, 0);
      @(negedge clk);
      chk("bypass_on_rs1", rs1_value, 32'h1);
      chk("bypass_off_rs1", nb_rs1_value, 32'hA5A5A5A5);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 7, 0, 0, 0, 0);
      @(negedge clk);
      chk("bypass_off_rs1_after", nb_rs1_value, 32'h1);
      @(posedge clk);
      #1;

      // asynchronous reset mid-cycle
      drive(1, 10, 32'h55, 0, 0, 1, 11, 0);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 10, 11, 0, 0, 0);
      @(negedge clk);
      chk("pre_reset_x10", rs1_value, 32'h55);
      chk("pre_reset_x11_busy", {31'h0, rs2_busy}, 32'h1);
      @(posedge clk);
      #1;
      chk("pre_reset_busy_count", {26'h0, busy_count}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_x10", rs1_value, 32'h0);
      chk("async_reset_busy_count", {26'h0, busy_count}, 32'h0);
      chk("async_reset_x11_busy", {31'h0, rs2_busy}, 32'h0);
      drive(1, 10, 32'h77, 10, 0, 1, 12, 0);
      #1;
      chk("reset_bypass_quiet", rs1_value, 32'h0);
      chk("reset_conflict_quiet", {31'h0, rsv_conflict}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 10, 12, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_x10", rs1_value, 32'h0);
      chk("post_reset_x12_busy", {31'h0, rs2_busy}, 32'h0);
      chk("post_reset_busy_count", {26'h0, busy_count}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning architectural register count (x0..x31).
REQ-003 The block SHALL have parameter BYPASS, default 1, meaning that same-cycle write-to-read forwarding is enabled.
REQ-004 Port list (name, direction, width, meaning), one clock, reset asynchronous active-low:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-low reset.
- rf_write_req  input  core::rf_write_req_t  writeback write (en, rd_num, rd_value).
- rs1_num  input  5  read port 1 register index.
- rs2_num  input  5  read port 2 register index.
- rs1_value  output  XLEN  read port 1 data.
- rs2_value  output  XLEN  read port 2 data.
- rs1_busy  output  1  rs1_num has an outstanding write.
- rs2_busy  output  1  rs2_num has an outstanding write.
- rsv_en  input  1  reserve request from decode/issue.
- rsv_num  input  5  register being reserved.
- rsv_conflict  output  1  reserve rejected because the target is already busy.
- flush  input  1  synchronous clear of all busy bits.
- busy_count  output  6  number of set busy bits.

Function
REQ-005 Storage SHALL be NUM_REGS x XLEN; x0 SHALL read 0 always; writes to x0 SHALL be discarded.
REQ-006 A write SHALL occur at the rising clk edge when rf_write_req.en=1 and rd_num!=0.
REQ-007 Reads SHALL be combinational, with zero-cycle latency from rsN_num to rsN_value.
REQ-008 With BYPASS=1, when rf_write_req.en=1 and rd_num==rsN_num!=0, rsN_value SHALL equal rf_write_req.rd_value in the same cycle; with BYPASS=0, rsN_value SHALL be the stored value.
REQ-009 Scoreboard: one busy bit per register; busy[0] SHALL be constant 0.
REQ-010 Reserve: rsv_en=1, rsv_num!=0, busy[rsv_num]=0 -> busy[rsv_num] SHALL set at the next edge.
REQ-011 Reserve conflict: rsv_en=1, rsv_num!=0, busy[rsv_num]=1 -> rsv_conflict SHALL be 1 combinationally that cycle, with no scoreboard change; the exception is REQ-013.
REQ-012 Writeback clear: rf_write_req.en=1 -> busy[rd_num] SHALL clear at the next edge.
REQ-013 If a reserve and a writeback target the same register in the same cycle, the writeback clear and the reserve set SHALL both apply, the reserve SHALL win (bit ends 1), and rsv_conflict SHALL be 0.
REQ-014 rsN_busy SHALL be busy[rsN_num] & ~(rf_write_req.en & rd_num==rsN_num), so that a completing write hides busy in the same cycle.
REQ-015 flush=1 SHALL clear all busy bits at the next edge and SHALL override any reserve that cycle; a writeback in that cycle SHALL still write data.
REQ-016 busy_count SHALL be a registered popcount of the busy bits, updated coherently with them, range 0..31.
REQ-017 rsv_en with rsv_num=0 SHALL be a no-op, with rsv_conflict=0.

Reset
REQ-018 rst=0 SHALL asynchronously clear all registers to 0, all busy bits to 0, and busy_count to 0.
REQ-019 During reset, rsN_value, rsN_busy and rsv_conflict SHALL read 0; writes and reserves SHALL be ignored until the first edge after rst rises.

Structure
REQ-020 XLEN, the register index width (5), and rf_write_req_t SHALL live in the core package; reg_file SHALL import them.
REQ-021 A sub-module rf_scoreboard (busy bits, conflict, busy_count) SHALL be instantiated; data storage SHALL remain in reg_file.

Verification
REQ-022 Write x5=0xDEADBEEF, then next cycle read rs1=5 -> rs1_value=0xDEADBEEF; write x0=0x1234 -> rs2_num=0 reads 0.
REQ-023 BYPASS=1: write x7=0xA5A5A5A5 while rs1_num=7 in the same cycle -> rs1_value=0xA5A5A5A5 that cycle, and rs1_busy=0 if x7 was reserved.
REQ-024 Reserve x3, then reserve x3 again -> rsv_conflict=1 on the second request, busy_count stays 1; writeback x3 -> busy_count=0.
REQ-025 Same cycle: reserve x9 and writeback x9 (x9 busy) -> x9 data updated, busy[9]=1, rsv_conflict=0, busy_count unchanged.
REQ-026 Reserve x1, x2, x4; then flush together with reserve x6 -> busy_count=0 and x6 not busy.
REQ-027 Load x10=0x55 and reserve x11, then pulse rst low mid-cycle -> x10 immediately reads 0 and busy_count=0 without waiting for a clk edge.
